// File: rtl/tdm_pkg.sv
// rtl/tdm_pkg.sv - shared types and helpers for the tdm mux/demux path
package tdm_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } tdm_state_e;

  // Slot counter width; a one-slot frame still needs one bit to hold slot 0
  function automatic int slot_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tdm_demux_if.sv
// rtl/tdm_demux_if.sv - serial word input and channel register outputs of tdm_demux
interface tdm_demux_if #(
  parameter int N_CH = 4,
  parameter int W    = 8
);

  logic [W-1:0]      din;
  logic              din_valid;
  logic              frame_sync;
  logic [N_CH*W-1:0] dout;
  logic [N_CH-1:0]   ch_valid;
  logic              frame_done;
  logic              locked;
  logic              sync_err;

  // Link receiver side: drives the stream, observes the channel outputs
  modport master (
    output din, din_valid, frame_sync,
    input  dout, ch_valid, frame_done, locked, sync_err
  );

  // Demux side
  modport slave (
    input  din, din_valid, frame_sync,
    output dout, ch_valid, frame_done, locked, sync_err
  );

endinterface

// File: rtl/tdm_slot_counter.sv
// rtl/tdm_slot_counter.sv - mod-N slot counter with enable, load-to-1 and clear
module tdm_slot_counter
  import tdm_pkg::*;
#(
  parameter int N  = 4,
  parameter int SW = slot_w(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en_i,
  input  logic          load1_i,
  input  logic          clr_i,
  output logic [SW-1:0] slot_o,
  output logic          last_o
);

  localparam logic [SW-1:0] LAST = SW'(N - 1);
  // Slot after slot 0; with a single slot that wraps straight back to 0
  localparam logic [SW-1:0] ONE  = (N == 1) ? '0 : SW'(1);

  logic [SW-1:0] slot_q;

  // Clear wins over load, load wins over advance; wrap at N-1 so any N works
  always_ff @(posedge clk) begin
    if (!rst_n || clr_i) begin
      slot_q <= '0;
    end else if (load1_i) begin
      slot_q <= ONE;
    end else if (en_i) begin
      slot_q <= (slot_q == LAST) ? '0 : slot_q + 1'b1;
    end
  end

  assign slot_o = slot_q;
  assign last_o = (slot_q == LAST);

endmodule

// File: rtl/tdm_demux.sv
// rtl/tdm_demux.sv - frame-aligned demux of a word-serial stream into channel registers
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int W    = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  tdm_demux_if.slave bus
);

  localparam int SW = slot_w(N_CH);

  tdm_state_e        state_q, state_d;
  logic [N_CH*W-1:0] dout_q, dout_d;
  logic [N_CH-1:0]   ch_valid_q, ch_valid_d;
  logic              frame_done_q, frame_done_d;
  logic              sync_err_q, sync_err_d;

  logic [SW-1:0]     slot;
  logic              slot_last;
  logic              cnt_en, cnt_load1, cnt_clr;
  logic              wr;
  logic [SW-1:0]     wr_slot;

  tdm_slot_counter #(.N(N_CH), .SW(SW)) u_slot_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (cnt_en),
    .load1_i (cnt_load1),
    .clr_i   (cnt_clr),
    .slot_o  (slot),
    .last_o  (slot_last)
  );

  // Decide slot routing, alignment errors and counter action for the accepted word
  always_comb begin
    state_d      = state_q;
    dout_d       = dout_q;
    ch_valid_d   = '0;
    frame_done_d = 1'b0;
    sync_err_d   = 1'b0;
    cnt_en       = 1'b0;
    cnt_load1    = 1'b0;
    cnt_clr      = 1'b0;
    wr           = 1'b0;
    wr_slot      = '0;

    if (bus.din_valid) begin
      case (state_q)
        HUNT: begin
          // Acquisition: only a sync word is usable; never counts as a finished frame
          if (bus.frame_sync) begin
            wr        = 1'b1;
            cnt_load1 = 1'b1;
            state_d   = LOCKED;
          end
        end
        LOCKED: begin
          if (bus.frame_sync) begin
            // Sync restarts the frame; early when we expected a non-zero slot
            wr           = 1'b1;
            cnt_load1    = 1'b1;
            sync_err_d   = (slot != '0);
            frame_done_d = slot_last && (slot == '0);
          end else if (slot == '0) begin
            // Slot 0 must carry sync; alignment lost, drop word and re-hunt
            sync_err_d = 1'b1;
            cnt_clr    = 1'b1;
            state_d    = HUNT;
          end else begin
            wr           = 1'b1;
            wr_slot      = slot;
            cnt_en       = 1'b1;
            frame_done_d = slot_last;
          end
        end
        default: state_d = HUNT;
      endcase
    end

    if (wr) begin
      dout_d[int'(wr_slot)*W +: W] = bus.din;
      ch_valid_d[wr_slot]          = 1'b1;
    end
  end

  // Register FSM state and every output; reset discards any partial frame
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= HUNT;
      dout_q       <= '0;
      ch_valid_q   <= '0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      dout_q       <= dout_d;
      ch_valid_q   <= ch_valid_d;
      frame_done_q <= frame_done_d;
      sync_err_q   <= sync_err_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.ch_valid   = ch_valid_q;
  assign bus.frame_done = frame_done_q;
  assign bus.sync_err   = sync_err_q;
  assign bus.locked     = (state_q == LOCKED);

endmodule

// File: tb/tb_tdm_demux.sv
// tb/tb_tdm_demux.sv - table-driven scoreboard bench for tdm_demux (N_CH=4, W=8)
module tb_tdm_demux;

  localparam int N_CH = 4;
  localparam int W    = 8;

  typedef struct {
    logic [31:0] dout;
    logic [3:0]  cv;
    logic        fd;
    logic        lk;
    logic        se;
  } exp_t;

  typedef struct {
    logic  rst_n;
    logic  v;
    logic  s;
    logic [7:0] d;
    exp_t  e;
  } vec_t;

  logic clk;
  logic rst_n;

  tdm_demux_if #(.N_CH(N_CH), .W(W)) bus ();

  tdm_demux #(.N_CH(N_CH), .W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vec_t tbl[$];
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fails  = 0;

  task automatic add(input logic r, input logic v, input logic s, input logic [7:0] d,
                     input logic [31:0] dout, input logic [3:0] cv,
                     input logic fd, input logic lk, input logic se);
    vec_t x;
    x.rst_n = r; x.v = v; x.s = s; x.d = d;
    x.e.dout = dout; x.e.cv = cv; x.e.fd = fd; x.e.lk = lk; x.e.se = se;
    tbl.push_back(x);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fails++;
      $display("FAIL %s step %0d: got %h, expected %h", name, idx, act, req);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare after the edge
  task automatic apply(input vec_t x, input int idx);
    exp_t e;
    rst_n          = x.rst_n;
    bus.din_valid  = x.v;
    bus.frame_sync = x.s;
    bus.din        = x.d;
    exp_q.push_back(x.e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fails++;
      $display("FAIL scoreboard step %0d: queue empty", idx);
    end else begin
      e = exp_q.pop_front();
      chk("dout",       idx, bus.dout,                 e.dout);
      chk("ch_valid",   idx, {28'd0, bus.ch_valid},    {28'd0, e.cv});
      chk("frame_done", idx, {31'd0, bus.frame_done},  {31'd0, e.fd});
      chk("locked",     idx, {31'd0, bus.locked},      {31'd0, e.lk});
      chk("sync_err",   idx, {31'd0, bus.sync_err},    {31'd0, e.se});
    end
  endtask

  task automatic step(input logic r, input logic v, input logic s, input logic [7:0] d,
                      input logic [31:0] dout, input logic [3:0] cv,
                      input logic fd, input logic lk, input logic se, input int idx);
    vec_t x;
    x.rst_n = r; x.v = v; x.s = s; x.d = d;
    x.e.dout = dout; x.e.cv = cv; x.e.fd = fd; x.e.lk = lk; x.e.se = se;
    apply(x, idx);
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.din_valid  = 1'b0;
    bus.frame_sync = 1'b0;
    bus.din        = '0;

    //   rst v  s  din    dout          cv       fd lk se
    // reset with inputs toggling, then unsynced words dropped
    add(0, 1, 1, 8'hFF, 32'h00000000, 4'b0000, 0, 0, 0);
    add(0, 1, 0, 8'h5A, 32'h00000000, 4'b0000, 0, 0, 0);
    add(1, 1, 0, 8'h11, 32'h00000000, 4'b0000, 0, 0, 0);
    add(1, 1, 0, 8'h11, 32'h00000000, 4'b0000, 0, 0, 0);
    // full-rate frame
    add(1, 1, 1, 8'hA0, 32'h000000A0, 4'b0001, 0, 1, 0);
    add(1, 1, 0, 8'hA1, 32'h0000A1A0, 4'b0010, 0, 1, 0);
    add(1, 1, 0, 8'hA2, 32'h00A2A1A0, 4'b0100, 0, 1, 0);
    add(1, 1, 0, 8'hA3, 32'hA3A2A1A0, 4'b1000, 1, 1, 0);
    // sync without valid is ignored
    add(1, 0, 1, 8'hFF, 32'hA3A2A1A0, 4'b0000, 0, 1, 0);
    // two frames with 3-cycle gaps mid-frame
    add(1, 1, 1, 8'hB0, 32'hA3A2A1B0, 4'b0001, 0, 1, 0);
    add(1, 1, 0, 8'hB1, 32'hA3A2B1B0, 4'b0010, 0, 1, 0);
    for (int i = 0; i < 3; i++) add(1, 0, 0, 8'hEE, 32'hA3A2B1B0, 4'b0000, 0, 1, 0);
    add(1, 1, 0, 8'hB2, 32'hA3B2B1B0, 4'b0100, 0, 1, 0);
    add(1, 1, 0, 8'hB3, 32'hB3B2B1B0, 4'b1000, 1, 1, 0);
    add(1, 1, 1, 8'hC0, 32'hB3B2B1C0, 4'b0001, 0, 1, 0);
    add(1, 1, 0, 8'hC1, 32'hB3B2C1C0, 4'b0010, 0, 1, 0);
    for (int i = 0; i < 3; i++) add(1, 0, 0, 8'hDD, 32'hB3B2C1C0, 4'b0000, 0, 1, 0);
    add(1, 1, 0, 8'hC2, 32'hB3C2C1C0, 4'b0100, 0, 1, 0);
    add(1, 1, 0, 8'hC3, 32'hC3C2C1C0, 4'b1000, 1, 1, 0);
    // early sync at slot 2
    add(1, 1, 1, 8'h10, 32'hC3C2C110, 4'b0001, 0, 1, 0);
    add(1, 1, 0, 8'h11, 32'hC3C21110, 4'b0010, 0, 1, 0);
    add(1, 1, 1, 8'h20, 32'hC3C21120, 4'b0001, 0, 1, 1);
    add(1, 1, 0, 8'h21, 32'hC3C22120, 4'b0010, 0, 1, 0);
    add(1, 1, 0, 8'h22, 32'hC3222120, 4'b0100, 0, 1, 0);
    add(1, 1, 0, 8'h23, 32'h23222120, 4'b1000, 1, 1, 0);
    // missed sync at slot 0, then reacquire
    add(1, 1, 0, 8'h55, 32'h23222120, 4'b0000, 0, 0, 1);
    add(1, 1, 0, 8'h77, 32'h23222120, 4'b0000, 0, 0, 0);
    add(1, 1, 1, 8'h66, 32'h23222166, 4'b0001, 0, 1, 0);

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // reset for one cycle after slot 2, then a fresh frame maps from ch0
    step(1, 1, 0, 8'h67, 32'h23226766, 4'b0010, 0, 1, 0, 100);
    step(1, 1, 0, 8'h68, 32'h23686766, 4'b0100, 0, 1, 0, 101);
    step(0, 1, 0, 8'h69, 32'h00000000, 4'b0000, 0, 0, 0, 102);
    step(1, 1, 0, 8'h70, 32'h00000000, 4'b0000, 0, 0, 0, 103);
    step(1, 1, 1, 8'h80, 32'h00000080, 4'b0001, 0, 1, 0, 104);
    step(1, 1, 0, 8'h81, 32'h00008180, 4'b0010, 0, 1, 0, 105);
    step(1, 1, 0, 8'h82, 32'h00828180, 4'b0100, 0, 1, 0, 106);
    step(1, 1, 0, 8'h83, 32'h83828180, 4'b1000, 1, 1, 0, 107);
    // sync at slot 3 is early: error, ch0 rewritten, no frame_done
    step(1, 1, 1, 8'h90, 32'h83828190, 4'b0001, 0, 1, 0, 108);
    step(1, 1, 0, 8'h91, 32'h83829190, 4'b0010, 0, 1, 0, 109);
    step(1, 1, 0, 8'h92, 32'h83929190, 4'b0100, 0, 1, 0, 110);
    step(1, 1, 1, 8'h94, 32'h83929194, 4'b0001, 0, 1, 1, 111);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/tdm_demux.md
Name: tdm_demux

Overview:
- Receive-side partner of the time-division mux path.
- Takes a word-serial stream with a frame-sync marker and routes each word to its channel slot.
- Each channel word is held in an output register, with per-channel valid strobes.
- Sits between the serial link receiver and the per-channel consumers; tracks frame alignment and flags sync errors.

Parameters:
- N_CH, 4, number of channels (slots per frame), >= 1
- W, 8, data word width in bits

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst_n  input  1  synchronous reset, active low
- din  input  W  serial stream word
- din_valid  input  1  din carries a word this cycle
- frame_sync  input  1  marks the din word as slot 0; qualified by din_valid
- dout  output  N_CH*W  channel registers; channel k at bits [k*W +: W]
- ch_valid  output  N_CH  one-cycle pulse: channel k register updated this cycle
- frame_done  output  1  one-cycle pulse: slot N_CH-1 written in LOCKED
- locked  output  1  high while in LOCKED state
- sync_err  output  1  one-cycle pulse on alignment error

Behaviour:
- Reset (rst_n low at clk edge):
  - dout = 0, ch_valid = 0, frame_done = 0, sync_err = 0, locked = 0
  - slot counter = 0, state = HUNT
  - Reset mid-frame discards the partial frame.
- Accept condition: din_valid = 1. frame_sync without din_valid is ignored.
- All outputs are registered. A word accepted at edge t appears on dout, with its ch_valid bit, after edge t; latency is 1 clk.
- Non-updated channel registers hold their value. ch_valid has at most one bit set per cycle.
- State HUNT:
  - Accepted word without frame_sync: dropped; no output change.
  - Accepted word with frame_sync: written to ch0, ch_valid[0] pulses, slot counter = 1 (mod N_CH), go to LOCKED.
- State LOCKED, accepted word at slot s, where s is the expected slot:
  - s != 0, no frame_sync: write ch s, pulse ch_valid[s]. Counter = s+1, wrapping N_CH-1 -> 0.
  - s != 0, frame_sync set (early sync): sync_err pulses. Word is treated as slot 0: write ch0, ch_valid[0], counter = 1. Stay LOCKED. The partial frame is not completed, so no frame_done.
  - s == 0, frame_sync set: normal; write ch0, counter = 1.
  - s == 0, no frame_sync (missed sync): sync_err pulses, word dropped, counter = 0, go to HUNT.
- frame_done pulses in the same cycle as ch_valid[N_CH-1] for a LOCKED write to slot N_CH-1.
- N_CH = 1:
  - Every LOCKED word is slot 0 and requires frame_sync.
  - frame_done pulses with each ch_valid[0] write in LOCKED, but not on the HUNT-to-LOCKED acquisition word.
- Gaps: din_valid low stalls the counter indefinitely; there is no timeout.
- Back-to-back words at full rate (din_valid held high) are supported with no bubbles.
- Slot counter width = max(1, clog2(N_CH)). Wrap compares against N_CH-1, so non-power-of-2 N_CH is supported.

Decomposition:
- Shared package tdm_pkg:
  - state encoding (HUNT = 0, LOCKED = 1)
  - slot-width function max(1, clog2(n)), shared with the transmit-side tdm mux
- One sub-module: tdm_slot_counter.
  - Mod-N_CH counter with enable, synchronous load-to-1 and clear.
  - Outputs: slot value, last-slot flag.
- Channel register bank and FSM live in tdm_demux.

Test Plan:
- Reset with inputs toggling -> all outputs 0, locked = 0. Words 0x11 with no sync -> dropped, dout stays 0.
- N_CH = 4, sync on 0xA0, then 0xA1, 0xA2, 0xA3 back-to-back -> dout = 0xA3A2A1A0. ch_valid = 0001, 0010, 0100, 1000 on successive cycles. frame_done with 1000. locked = 1 after the first word.
- Two frames separated by din_valid gaps of 3 cycles mid-frame -> the same slot mapping holds, no sync_err, frame_done once per frame.
- Early sync: sync on 0x10, then 0x11, then 0x20 with sync -> sync_err pulse. ch0 = 0x20, ch1 = 0x11, no frame_done. Next word 0x21 lands in ch1.
- Missed sync: full frame, then 0x55 without sync at slot 0 -> sync_err pulse, locked = 0, 0x55 dropped. Next sync word 0x66 -> ch0 = 0x66, relocked.
- rst_n low for 1 cycle after slot 2 of a frame -> all outputs cleared, HUNT. The subsequent sync frame maps from ch0.
